// File: rtl/frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : frame_rx
// Description : Serial frame receiver. Shifts DATA_W bits LSB-first inside a
//               receive window, hands the completed word to a one-entry
//               valid/ready output register, and flags truncated frames and
//               words dropped while the output register is still full.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_i,
    input  logic              init_i,
    input  logic              recv_en_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              frame_err_o,
    output logic              overrun_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;
    logic [DATA_W-1:0]  w_word;
    logic               w_complete;

    // Word as it would look after sampling data_i this cycle; a 1-bit frame
    // has no older bits to keep.
    if (DATA_W == 1) begin : g_word_w1
        assign w_word = data_i;
    end else begin : g_word_wn
        assign w_word = {data_i, shift_q[DATA_W-1:1]};
    end

    // Frame FSM: start on init, sample while the window is open, abort on a
    // closed window or a restart.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        err_d      = 1'b0;
        w_complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_i) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            SHIFT: begin
                if (init_i) begin
                    // Restart: the start-bit cycle is never sampled.
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (!recv_en_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    shift_d   = w_word;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        w_complete = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load on completion when free or being drained this
    // cycle, otherwise flag an overrun; a handshake alone empties it.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (w_complete) begin
            if (!valid_q || ready_i) begin
                data_d  = w_word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q == SHIFT);
    assign frame_err_o = err_q;
    assign overrun_o   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_rx
// Description : Scoreboard bench for frame_rx: directed scenarios plus
//               random traffic compared against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_rx;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              data_i = 1'b0;
    logic              init_i = 1'b0;
    logic              recv_en_i = 1'b0;
    logic              ready_i = 1'b0;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              busy_o;
    logic              frame_err_o;
    logic              overrun_o;

    frame_rx #(.DATA_W(DATA_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .init_i     (init_i),
        .recv_en_i  (recv_en_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int busy_acc = 0;

    // Frame-level reference model
    bit                in_frame = 1'b0;
    bit                bits_q[$];
    bit                m_valid = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_err = 1'b0;
    bit                m_ovr = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the rules of one clock edge to the model using the driven inputs.
    task automatic model_edge();
        bit                done;
        logic [DATA_W-1:0] word;
        done = 1'b0;
        word = '0;
        if (rst_i) begin
            in_frame = 1'b0;
            bits_q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
            m_ovr   = 1'b0;
            exp_q.delete();
            return;
        end
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (!in_frame) begin
            if (init_i) begin
                in_frame = 1'b1;
                bits_q.delete();
            end
        end else if (init_i) begin
            m_err = 1'b1;
            bits_q.delete();
        end else if (!recv_en_i) begin
            m_err = 1'b1;
            in_frame = 1'b0;
        end else begin
            bits_q.push_back(data_i);
            if (bits_q.size() == DATA_W) begin
                for (int i = 0; i < DATA_W; i++) word[i] = bits_q[i];
                done = 1'b1;
                in_frame = 1'b0;
            end
        end
        if (done) begin
            if (!m_valid || ready_i) begin
                m_data  = word;
                m_valid = 1'b1;
                exp_q.push_back(word);
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && ready_i) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit rst, input bit init, input bit en, input bit d, input bit rdy);
        rst_i     = rst;
        init_i    = init;
        recv_en_i = en;
        data_i    = d;
        ready_i   = rdy;
        @(posedge clk);
        model_edge();
        #1;
        busy_acc += int'(busy_o);
    endtask

    task automatic bits(input logic [DATA_W-1:0] w, input int n, input bit rdy, input bit rdy_last);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b1, w[i], (i == DATA_W - 1) ? rdy_last : rdy);
    endtask

    task automatic frame(input logic [DATA_W-1:0] w, input int n, input bit rdy, input bit rdy_last);
        step(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        bits(w, n, rdy, rdy_last);
    endtask

    // Monitor: per-cycle output comparison and scoreboard pop on handshake.
    always @(negedge clk) begin
        logic [DATA_W-1:0] w;
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        chk("busy_o", 32'(busy_o), 32'(in_frame));
        chk("frame_err_o", 32'(frame_err_o), 32'(m_err));
        chk("overrun_o", 32'(overrun_o), 32'(m_ovr));
        chk("data_o", 32'(data_o), 32'(m_data));
        if (valid_o && ready_i && !rst_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: got word %0h expected none", data_o);
            end else begin
                w = exp_q.pop_front();
                chk("sb_word", 32'(data_o), 32'(w));
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);

        // 8'hA5 with a long window and a ready consumer
        busy_acc = 0;
        frame(8'hA5, 8, 1'b1, 1'b1);
        chk("a5_valid", 32'(valid_o), 32'd1);
        chk("a5_data", 32'(data_o), 32'hA5);
        repeat (7) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b1);
        chk("a5_busy_cycles", 32'(busy_acc), 32'd8);

        // Window closes after 5 bits
        frame(8'hFF, 5, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("trunc_err", 32'(frame_err_o), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("trunc_err_once", 32'(frame_err_o), 32'd0);
        chk("trunc_no_valid", 32'(valid_o), 32'd0);
        frame(8'h3C, 8, 1'b1, 1'b1);
        chk("3c_data", 32'(data_o), 32'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun while the consumer stalls
        frame(8'h11, 8, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'h22, 8, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(overrun_o), 32'd1);
        chk("ovr_hold", 32'(data_o), 32'h11);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drain", 32'(valid_o), 32'd0);

        // Ready exactly in the completion cycle
        frame(8'h11, 8, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'h22, 8, 1'b0, 1'b1);
        chk("swap_data", 32'(data_o), 32'h22);
        chk("swap_valid", 32'(valid_o), 32'd1);
        chk("swap_no_ovr", 32'(overrun_o), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Restart after 3 bits
        frame(8'h0F, 3, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("restart_err", 32'(frame_err_o), 32'd1);
        bits(8'hF0, 8, 1'b1, 1'b1);
        chk("f0_data", 32'(data_o), 32'hF0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame with a held word
        frame(8'h11, 8, 1'b0, 1'b0);
        frame(8'h99, 4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_mid_valid", 32'(valid_o), 32'd0);
        chk("rst_mid_data", 32'(data_o), 32'd0);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        frame(8'h5A, 8, 1'b1, 1'b1);
        chk("5a_data", 32'(data_o), 32'h5A);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 256) == 0,
                 ($urandom % 10) == 0,
                 ($urandom % 16) != 0,
                 1'($urandom),
                 1'($urandom));
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_rx.md
FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (legal range 1..15).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port data_i  input  1  serial data line, already synchronous to clk_i.
REQ-005 SHALL have port init_i  input  1  one-cycle pulse marking the start-bit cycle of a frame.
REQ-006 SHALL have port recv_en_i  input  1  receive window from the start detector; high while frame bits are valid.
REQ-007 SHALL have port ready_i  input  1  consumer accepts data_o this cycle when valid_o=1.
REQ-008 SHALL have port data_o  output  DATA_W  received word, bit 0 = first bit received.
REQ-009 SHALL have port valid_o  output  1  data_o holds an unconsumed word.
REQ-010 SHALL have port busy_o  output  1  frame shift in progress.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse, frame truncated and discarded.
REQ-012 SHALL have port overrun_o  output  1  one-cycle pulse, completed frame dropped because the output register is full.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT, plus bit counter bit_cnt (width ceil(log2(DATA_W+1))) and shift register shift_r[DATA_W-1:0].
REQ-014 IDLE: init_i=1 -> SHIFT next cycle, bit_cnt<=0, shift_r<=0; data_i in the init cycle (start bit) is not sampled.
REQ-015 IDLE: recv_en_i and data_i ignored; no pulses generated.
REQ-016 SHIFT, init_i=0, recv_en_i=1: shift_r<={data_i, shift_r[DATA_W-1:1]} (LSB first), bit_cnt<=bit_cnt+1.
REQ-017 SHIFT sample with bit_cnt==DATA_W-1 completes the frame: next state IDLE; completed word = {data_i, shift_r[DATA_W-1:1]}.
REQ-018 recv_en_i remaining high after completion SHALL be ignored (IDLE), no error.
REQ-019 SHIFT, init_i=0, recv_en_i=0 (window closed early): frame_err_o=1 next cycle, partial word discarded, next state IDLE.
REQ-020 SHIFT, init_i=1: frame_err_o=1 next cycle, restart as in REQ-014 (stay SHIFT, bit_cnt<=0, shift_r<=0), no sample that cycle.
REQ-021 On completion, if valid_o=0 or (valid_o=1 and ready_i=1) in the same cycle: data_o<=completed word, valid_o<=1 next cycle (latency 1 cycle from last sampled bit).
REQ-022 On completion with valid_o=1 and ready_i=0: word dropped, data_o and valid_o unchanged, overrun_o=1 next cycle.
REQ-023 valid_o=1 and ready_i=1 with no completion that cycle: valid_o<=0 next cycle; data_o holds last value.
REQ-024 data_o SHALL be stable while valid_o=1 and ready_i=0.
REQ-025 busy_o SHALL equal (state==SHIFT), registered.
REQ-026 frame_err_o and overrun_o SHALL be registered, high for exactly one cycle per event, and cannot both fire for the same frame.

Reset
REQ-027 rst_i=1 at a clock edge SHALL force: state IDLE, bit_cnt=0, shift_r=0, data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
REQ-028 Reset SHALL take priority over all inputs, including mid-frame and with valid_o=1; the partial frame and held word are discarded with no pulses.
REQ-029 After rst_i deasserts, the first init_i SHALL be honoured the same cycle.

Verification
REQ-030 DATA_W=8, init_i pulse, then recv_en_i=1 for 15 cycles with data_i bits 1,0,1,0,0,1,0,1, ready_i=1 -> valid_o high 1 cycle after 8th bit, data_o=8'hA5, no pulses, busy_o high exactly 8 cycles.
REQ-031 recv_en_i drops after 5 bits -> frame_err_o single pulse, valid_o stays 0, next full frame 8'h3C received correctly.
REQ-032 Frame 8'h11 received, ready_i=0, second frame 8'h22 completes -> overrun_o pulse, data_o stays 8'h11; ready_i=1 then clears valid_o.
REQ-033 valid_o=1 (8'h11), ready_i=1 in exact completion cycle of 8'h22 -> data_o=8'h22 next cycle, valid_o stays 1, no overrun_o.
REQ-034 init_i reasserted after 3 bits -> frame_err_o pulse, new frame 8'hF0 received intact.
REQ-035 rst_i asserted after 4 bits with valid_o=1 -> all outputs 0 next cycle, no pulses; subsequent frame 8'h5A received normally.
